sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous single-clock FIFO that serves as the design under test for the FIFO verification environment. Its input pins (data_in, wr_en, rd_en) are driven by the stimulus stage, and its output pins (data_out and status flags) are sampled one negedge later by the monitor. Data is buffered in a circular memory with read and write pointers and an occupancy counter. The block reports write acknowledge, overflow, underflow and full/empty/almost levels every cycle.

## Interface
Parameters:
- FIFO_WIDTH, 16: data word width in bits.
- FIFO_DEPTH, 8: number of entries; must be a power of two, minimum 4.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_out  out  FIFO_WIDTH  read data, registered.
- wr_ack  out  1  registered; previous-edge write was accepted.
- overflow  out  1  registered; previous-edge write was rejected because the FIFO was full.
- underflow  out  1  registered; previous-edge read was rejected because the FIFO was empty.
- full  out  1  combinational; count == FIFO_DEPTH.
- empty  out  1  combinational; count == 0.
- almostfull  out  1  combinational; count == FIFO_DEPTH-1.
- almostempty  out  1  combinational; count == 1.

## Operation
- State:
  - wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits; wrap modulo FIFO_DEPTH through natural overflow.
  - count, $clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Write accepted when wr_en && !full:
  - mem[wr_ptr] <= data_in; wr_ptr increments; wr_ack <= 1.
- Write rejected when wr_en && full:
  - overflow <= 1; wr_ack <= 0; memory and pointers unchanged.
- No write request: wr_ack <= 0, overflow <= 0.
- Read accepted when rd_en && !empty:
  - data_out <= mem[rd_ptr]; rd_ptr increments; underflow <= 0.
- Read rejected when rd_en && empty:
  - underflow <= 1; data_out holds.
- No read request: data_out holds, underflow <= 0.
- Count update:
  - +1 on accepted write only.
  - −1 on accepted read only.
  - Unchanged when both are accepted or neither is.
- Simultaneous wr_en and rd_en:
  - Empty: the write is accepted; the read is rejected with underflow=1.
  - Full: the read is accepted; the write is rejected with overflow=1.
  - Otherwise: both are accepted and count is unchanged.
- Reset:
  - Pointers, count, data_out, wr_ack, overflow and underflow all go to 0.
  - Memory contents are not cleared.
  - After reset: empty=1; full, almostfull and almostempty = 0.
- Reset while requests are pending: rst has priority and all requests on that edge are dropped.

## Timing
- Write-to-read latency: a word written at edge N can be read at edge N+1. data_out is valid after that edge and is sampled by the monitor at the following negedge.
- wr_ack, overflow and underflow are single-cycle pulses reflecting the most recent edge. They assert continuously if the condition repeats on consecutive edges.
- Flags follow count with zero delay after each edge. full, empty, almostfull and almostempty are mutually exclusive for FIFO_DEPTH ≥ 4.
- No back-pressure handshake. Rejected requests are dropped, not retried.

## Structure
- Default FIFO_WIDTH and FIFO_DEPTH constants go in shared_pkg so the bench, transaction class and DUT agree.
- Optional sub-module fifo_mem: a 1-write/1-read register array.
- Pointer, count and flag logic stays in sync_fifo.

## Test plan
- Reset: assert rst for 2 cycles with wr_en=1 → every registered output is 0, empty=1, and no write lands.
- Fill: write 0x0001..0x0008 on 8 consecutive edges → wr_ack=1 each cycle; almostfull after the 7th write; full after the 8th. A 9th write gives overflow=1, wr_ack=0, full stays 1.
- Drain: from full, read 8 times → data_out = 0x0001..0x0008 in order; almostempty after the 7th read; empty after the 8th. A 9th read gives underflow=1 and data_out holds 0x0008.
- Simultaneous on empty: wr_en=rd_en=1, data_in=0xABCD → wr_ack=1, underflow=1, count=1.
- Simultaneous on full: wr_en=rd_en=1 → overflow=1; data_out = oldest word; count=7.
- Wrap-around: 12 interleaved write/read pairs at count=3 → pointers wrap, order is preserved, count stays 3, and no flag pulses occur.
- Mid-operation reset: count=5, then rst for 1 cycle → count=0 and empty=1. A subsequent write of 0x5555 followed by a read returns 0x5555.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared FIFO sizing constants.
// Bench and DUT both take their defaults from here.
package shared_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

endpackage

// File: rtl/sync_fifo_mem.sv
// fifo_mem: one-write/one-read register array.
// Write on posedge; read port is asynchronous.
module fifo_mem
  import shared_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never cleared; only written words are ever read back.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO.
// Pointers, occupancy count, pulses and level flags.
module sync_fifo
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = shared_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_AFUL = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [FIFO_WIDTH-1:0] rd_data;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  mem_we;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign almostfull  = (count == CNT_AFUL);
  assign almostempty = (count == CNT_ONE);

  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  // Reset wins: a write on a reset edge must not land.
  assign mem_we = wr_ok && !rst;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, registered read data and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_out <= rd_data;
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: net effect of accepted write and read.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed + random checks of sync_fifo
// against a queue-based reference model.
module tb_sync_fifo;
  import shared_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  int total = 0;
  int bad   = 0;

  logic [FIFO_WIDTH-1:0] q [$];
  logic [FIFO_WIDTH-1:0] m_dout;
  logic                  m_ack;
  logic                  m_ovf;
  logic                  m_udf;

  sync_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".data_out"},    32'(data_out),    32'(m_dout));
    chk({tag, ".wr_ack"},      32'(wr_ack),      32'(m_ack));
    chk({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    chk({tag, ".underflow"},   32'(underflow),   32'(m_udf));
    chk({tag, ".full"},        32'(full),        32'(n == FIFO_DEPTH));
    chk({tag, ".empty"},       32'(empty),       32'(n == 0));
    chk({tag, ".almostfull"},  32'(almostfull),  32'(n == FIFO_DEPTH - 1));
    chk({tag, ".almostempty"}, 32'(almostempty), 32'(n == 1));
  endtask

  // One clock: drive after negedge, model at posedge, check at negedge.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic rd, input logic [FIFO_WIDTH-1:0] d);
    bit was_full;
    bit was_empty;
    rst     = r;
    wr_en   = w;
    rd_en   = rd;
    data_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ack  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      was_full  = (q.size() == FIFO_DEPTH);
      was_empty = (q.size() == 0);
      m_ack = w && !was_full;
      m_ovf = w && was_full;
      m_udf = rd && was_empty;
      if (rd && !was_empty) m_dout = q.pop_front();
      if (m_ack) q.push_back(d);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [FIFO_WIDTH-1:0] d);
    step(tag, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input string tag);
    step(tag, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic both(input string tag, input logic [FIFO_WIDTH-1:0] d);
    step(tag, 1'b0, 1'b1, 1'b1, d);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    m_dout = '0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);

    step("reset0", 1'b1, 1'b1, 1'b0, 16'h1111);
    step("reset1", 1'b1, 1'b1, 1'b0, 16'h2222);
    rd("post_reset_rd");

    for (int i = 1; i <= FIFO_DEPTH; i++)
      wr($sformatf("fill%0d", i), FIFO_WIDTH'(i));
    wr("fill_ovf", 16'h0009);
    wr("fill_ovf2", 16'h000A);

    for (int i = 1; i <= FIFO_DEPTH; i++)
      rd($sformatf("drain%0d", i));
    rd("drain_udf");
    chk("drain_hold", 32'(data_out), 32'h0008);

    both("sim_empty", 16'hABCD);
    chk("sim_empty_ae", 32'(almostempty), 32'd1);

    for (int i = 0; i < FIFO_DEPTH - 1; i++)
      wr($sformatf("refill%0d", i), FIFO_WIDTH'(16'h0100 + i));
    both("sim_full", 16'hEEEE);
    chk("sim_full_dout", 32'(data_out), 32'h0000ABCD);

    while (q.size() > 3) rd("to3");
    for (int i = 0; i < 12; i++)
      both($sformatf("wrap%0d", i), FIFO_WIDTH'(16'h0200 + i));

    while (q.size() < 5) wr("to5", FIFO_WIDTH'($urandom));
    step("mid_rst", 1'b1, 1'b0, 1'b0, '0);
    wr("post_wr", 16'h5555);
    rd("post_rd");
    chk("post_rd_val", 32'(data_out), 32'h5555);

    for (int i = 0; i < 300; i++)
      step($sformatf("rnd%0d", i), ($urandom_range(0, 49) == 0),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           FIFO_WIDTH'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
